// File: rtl/ssd_pkg.sv
// Shared constants and state encoding for the seven-segment display path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ssd_pkg;

  localparam int SSD_BIN_W  = 13;
  localparam int SSD_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ssd_state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
// Latency: purely combinational.
// Backpressure: none.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  // Corrected digit never exceeds 12, so 4-bit wraparound cannot occur.
  assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/ssd_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Latency: BIN_W cycles from the accepting edge to done; one conversion per BIN_W+2 cycles.
// Backpressure: start is accepted only in IDLE; requests while busy are dropped.
module ssd_bcd_converter
  import ssd_pkg::*;
#(
  parameter int BIN_W  = SSD_BIN_W,
  parameter int DIGITS = SSD_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int               CNT_W    = $clog2(BIN_W);
  localparam int               BCD_W    = 4 * DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  // The digit count must be able to hold the largest binary input.
  if ((64'd10 ** DIGITS) <= (64'd1 << BIN_W)) begin : g_width_check
    $error("ssd_bcd_converter: DIGITS too small for BIN_W");
  end

  ssd_state_t       state;
  ssd_state_t       state_nxt;
  logic [BIN_W-1:0] bin_sr;
  logic [BCD_W-1:0] scratch;
  logic [BCD_W-1:0] scratch_adj;
  logic [BCD_W-1:0] scratch_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_iter;

  // One corrector per scratch digit, all applied before the shift.
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (scratch[4*d +: 4]),
      .adj   (scratch_adj[4*d +: 4])
    );
  end

  // Shift corrected scratch left, pulling in the binary MSB.
  assign scratch_nxt = {scratch_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
  assign last_iter   = (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start only honoured in IDLE, DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state only.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath: load on accept, iterate in SHIFT, publish result on the final edge only.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_sr  <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr  <= bin_in;
            scratch <= '0;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          scratch <= scratch_nxt;
          bin_sr  <= {bin_sr[BIN_W-2:0], 1'b0};
          cnt     <= cnt + CNT_W'(1);
          if (last_iter) begin
            bcd_out <= scratch_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ssd_bcd_converter.sv
// Self-checking bench for ssd_bcd_converter against an arithmetic decimal model.
// Latency: checks done arrives 13 cycles after the accepting edge.
// Backpressure: checks starts during a conversion are dropped.
module tb_ssd_bcd_converter;

  logic        clk;
  logic        rst;
  logic [12:0] bin_in;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;

  int n_cmp = 0;
  int n_err = 0;

  ssd_bcd_converter dut (
    .clk     (clk),
    .rst     (rst),
    .bin_in  (bin_in),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Decimal digits by plain division, independent of the shift-and-add method.
  function automatic logic [15:0] ref_bcd(input int v);
    logic [3:0] d0, d1, d2, d3;
    d0 = 4'(v % 10);
    d1 = 4'((v / 10) % 10);
    d2 = 4'((v / 100) % 10);
    d3 = 4'((v / 1000) % 10);
    return {d3, d2, d1, d0};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full conversion with latency, result, hold-stability and pulse-width checks.
  task automatic run_conv(input int v, input string tag);
    logic [15:0] held;
    int          lat;
    bit          stable;
    held   = bcd_out;
    lat    = 0;
    stable = 1'b1;
    bin_in = v[12:0];
    start  = 1'b1;
    tick();
    start  = 1'b0;
    bin_in = 13'($urandom);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s accept: busy=%b want 1", tag, busy);
    end
    while (done !== 1'b1 && lat < 40) begin
      if (bcd_out !== held) stable = 1'b0;
      tick();
      lat++;
    end
    n_cmp++;
    if (lat !== 13) begin
      n_err++;
      $display("FAIL %s latency: got %0d want 13", tag, lat);
    end
    n_cmp++;
    if (bcd_out !== ref_bcd(v)) begin
      n_err++;
      $display("FAIL %s value %0d: bcd_out=%h want %h", tag, v, bcd_out, ref_bcd(v));
    end
    n_cmp++;
    if (stable !== 1'b1) begin
      n_err++;
      $display("FAIL %s hold: bcd_out moved before done (held %h)", tag, held);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s pulse: done=%b busy=%b want 0 0", tag, done, busy);
    end
  endtask

  task automatic test_reset;
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 16'h0000) begin
      n_err++;
      $display("FAIL reset: busy=%b done=%b bcd_out=%h want 0 0 0000", busy, done, bcd_out);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_directed;
    int vals[6] = '{0, 1234, 8191, 999, 4095, 1};
    foreach (vals[i]) run_conv(vals[i], "directed");
  endtask

  task automatic test_ignore_start;
    int          ndone;
    logic [15:0] res;
    ndone  = 0;
    res    = '0;
    bin_in = 13'd500;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin
        start  = 1'b1;
        bin_in = 13'd7;
      end
      if (i == 4) start = 1'b0;
      tick();
      if (done === 1'b1) begin
        ndone++;
        res = bcd_out;
      end
    end
    n_cmp++;
    if (ndone !== 1) begin
      n_err++;
      $display("FAIL ignore_count: done pulses=%0d want 1", ndone);
    end
    n_cmp++;
    if (res !== 16'h0500) begin
      n_err++;
      $display("FAIL ignore_value: bcd_out=%h want 0500", res);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    bin_in = 13'd4321;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b done=%b bcd_out=%h want 0 0 0000", busy, done, bcd_out);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || bcd_out !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_mid_after: busy=%b bcd_out=%h want 0 0000", busy, bcd_out);
    end
    run_conv(42, "after_reset");
  endtask

  task automatic test_back_to_back;
    int          vals[3] = '{10, 20, 30};
    int          dtime[3];
    logic [15:0] dval[3];
    int          accepted;
    int          ndone;
    logic        prev_busy;
    accepted  = 0;
    ndone     = 0;
    prev_busy = busy;
    bin_in    = 13'(vals[0]);
    start     = 1'b1;
    for (int t = 1; t <= 60 && ndone < 3; t++) begin
      tick();
      if (busy === 1'b1 && prev_busy === 1'b0) begin
        accepted++;
        if (accepted < 3) bin_in = 13'(vals[accepted]);
        else start = 1'b0;
      end
      if (done === 1'b1) begin
        dtime[ndone] = t;
        dval[ndone]  = bcd_out;
        ndone++;
      end
      prev_busy = busy;
    end
    start = 1'b0;
    n_cmp++;
    if (ndone !== 3) begin
      n_err++;
      $display("FAIL b2b_count: done pulses=%0d want 3", ndone);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (dval[k] !== ref_bcd(vals[k])) begin
          n_err++;
          $display("FAIL b2b_value[%0d]: bcd_out=%h want %h", k, dval[k], ref_bcd(vals[k]));
        end
      end
      for (int k = 1; k < 3; k++) begin
        n_cmp++;
        if (dtime[k] - dtime[k-1] !== 15) begin
          n_err++;
          $display("FAIL b2b_spacing[%0d]: gap=%0d want 15", k, dtime[k] - dtime[k-1]);
        end
      end
    end
    tick();
    tick();
  endtask

  task automatic test_random_sweep;
    run_conv(8191, "sweep_max");
    run_conv(0, "sweep_min");
    for (int i = 0; i < 1500; i++) begin
      run_conv(int'($urandom_range(8191, 0)), "sweep");
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
